// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared state encoding, widths and digit limit for bcd_to_binary
package bcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_INIT  = 3'b001,
        ST_SHIFT = 3'b011,
        ST_CHECK = 3'b010,
        ST_DONE  = 3'b110
    } state_t;

    localparam int BCD_W   = 16;
    localparam int BIN_W   = 16;
    localparam int SHIFT_N = 16;

    localparam logic [3:0] DIGIT_MAX = 4'd9;

    function automatic logic nibble_invalid(input logic [3:0] n);
        return n > DIGIT_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// rtl/bcd_digit_adjust.sv - reverse double-dabble digit correction: subtract 3 from digits of 8 or more
module bcd_digit_adjust (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd8) ? din - 4'd3 : din;

endmodule

// File: rtl/bcd_to_binary.sv
// rtl/bcd_to_binary.sv - sequential 4-digit packed BCD to binary converter, START/DONE handshake, 34 clocks
// Optional macro BCD2BIN_SIGNED_EN adds a SIGN input and two's-complement negation of the result.
module bcd_to_binary
    import bcd_pkg::*;
#(
    parameter int NDIG = 4,
    parameter int BW   = BIN_W
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic [BW-1:0] BCD,
`ifdef BCD2BIN_SIGNED_EN
    input  logic          SIGN,
`endif
    output logic [BW-1:0] BINOUT,
    output logic          DONE,
    output logic          ERR,
    output logic          BUSY
);

    state_t              state, state_d;
    logic [2*BW-1:0]     tmp, tmp_d;
    logic [4:0]          cnt, cnt_d;
    logic                err_flag, err_flag_d;
    logic [BW-1:0]       binout_d;
    logic                done_d, err_d;
    logic [BW-1:0]       adj;
    logic [BW-1:0]       result;
    logic                any_bad;

    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .din  (tmp[BW + 4*g +: 4]),
            .dout (adj[4*g +: 4])
        );
    end

    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            any_bad = any_bad | nibble_invalid(tmp[BW + 4*i +: 4]);
        end
    end

`ifdef BCD2BIN_SIGNED_EN
    logic sign_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sign_q <= 1'b0;
        end else if (state == ST_IDLE && START) begin
            sign_q <= SIGN;
        end
    end

    assign result = sign_q ? (~tmp[BW-1:0] + BW'(1)) : tmp[BW-1:0];
`else
    assign result = tmp[BW-1:0];
`endif

    always_comb begin
        state_d    = state;
        tmp_d      = tmp;
        cnt_d      = cnt;
        err_flag_d = err_flag;
        binout_d   = BINOUT;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    tmp_d   = {BCD, {BW{1'b0}}};
                    cnt_d   = '0;
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                err_flag_d = any_bad;
                state_d    = any_bad ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
                tmp_d   = {1'b0, tmp[2*BW-1:1]};
                cnt_d   = cnt + 5'd1;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                // after the last shift the upper field is already zero, so no correction
                if (cnt == 5'(SHIFT_N)) begin
                    state_d = ST_DONE;
                end else begin
                    tmp_d   = {adj, tmp[BW-1:0]};
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                tmp_d   = '0;
                cnt_d   = '0;
                if (err_flag) begin
                    err_d = 1'b1;
                end else begin
                    binout_d = result;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            tmp      <= '0;
            cnt      <= '0;
            err_flag <= 1'b0;
            BINOUT   <= '0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            state    <= state_d;
            tmp      <= tmp_d;
            cnt      <= cnt_d;
            err_flag <= err_flag_d;
            BINOUT   <= binout_d;
            DONE     <= done_d;
            ERR      <= err_d;
        end
    end

    assign BUSY = (state != ST_IDLE);

endmodule

// File: tb/tb_bcd_to_binary.sv
// tb/tb_bcd_to_binary.sv - scoreboard bench for bcd_to_binary; signed tests run when BCD2BIN_SIGNED_EN is defined
module tb_bcd_to_binary;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [15:0] BCD;
    logic [15:0] BINOUT;
    logic        DONE;
    logic        ERR;
    logic        BUSY;
`ifdef BCD2BIN_SIGNED_EN
    logic        SIGN;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [16:0] exp_q[$];
    logic [15:0] last_bin;

    always #5 CLK = ~CLK;

    bcd_to_binary dut (
        .CLK    (CLK),
        .RST    (RST),
        .START  (START),
        .BCD    (BCD),
`ifdef BCD2BIN_SIGNED_EN
        .SIGN   (SIGN),
`endif
        .BINOUT (BINOUT),
        .DONE   (DONE),
        .ERR    (ERR),
        .BUSY   (BUSY)
    );

    // decimal reference: {err, binout}; an invalid input keeps the previous result
    function automatic logic [16:0] model(input logic [15:0] bcd, input logic sgn, input logic [15:0] prev);
        int   v;
        logic bad;
        logic [3:0] d;
        v   = 0;
        bad = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            d = bcd[4*i +: 4];
            if (d > 4'd9) bad = 1'b1;
            v = v * 10 + int'(d);
        end
        if (bad) return {1'b1, prev};
        if (sgn) v = -v;
        return {1'b0, 16'(v)};
    endfunction

    task automatic push_exp(input logic [15:0] bcd, input logic sgn);
        logic [16:0] e;
        e = model(bcd, sgn, last_bin);
        exp_q.push_back(e);
        if (!e[16]) last_bin = e[15:0];
    endtask

    task automatic kick(input logic [15:0] bcd, input logic sgn);
        BCD   = bcd;
        START = 1'b1;
`ifdef BCD2BIN_SIGNED_EN
        SIGN  = sgn;
`endif
        push_exp(bcd, sgn);
        @(posedge CLK); #1;
        START = 1'b0;
    endtask

    task automatic await_done(input int exp_lat, input int restart_at, input logic [15:0] restart_bcd);
        int          lat;
        logic [16:0] e;
        lat = 0;
        do begin
            @(posedge CLK); #1;
            lat++;
            if (restart_at > 0 && lat == restart_at - 1) begin
                BCD   = restart_bcd;
                START = 1'b1;
            end
            if (restart_at > 0 && lat == restart_at) START = 1'b0;
            if (lat == 1 || lat == exp_lat - 1) begin
                n_checks++;
                if (BUSY !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy_mid: lat=%0d BUSY=%b, required 1", lat, BUSY);
                end
            end
        end while (DONE !== 1'b1 && lat < 60);
        n_checks++;
        if (DONE !== 1'b1 || lat != exp_lat) begin
            n_fail++;
            $display("FAIL latency: DONE=%b after %0d edges, required DONE=1 after %0d", DONE, lat, exp_lat);
        end
        e = 17'h0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        n_checks++;
        if ({ERR, BINOUT} !== e) begin
            n_fail++;
            $display("FAIL result: ERR=%b BINOUT=%h, required ERR=%b BINOUT=%h", ERR, BINOUT, e[16], e[15:0]);
        end
        n_checks++;
        if (BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_end: BUSY=%b in DONE cycle, required 0", BUSY);
        end
        @(posedge CLK); #1;
        n_checks++;
        if (DONE !== 1'b0 || ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL pulse: DONE=%b ERR=%b one cycle later, required 0 0", DONE, ERR);
        end
    endtask

    task automatic no_done(input int cycles, input string name);
        logic seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(posedge CLK); #1;
            if (DONE === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL %s: unexpected DONE seen=%b, required 0", name, seen);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        n_checks++;
        if (BINOUT !== 16'h0000 || DONE !== 1'b0 || ERR !== 1'b0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: BINOUT=%h DONE=%b ERR=%b BUSY=%b, required 0000 0 0 0", BINOUT, DONE, ERR, BUSY);
        end
        last_bin = 16'h0000;
    endtask

    task automatic test_convert();
        logic [15:0] b;
        kick(16'h0000, 1'b0); await_done(34, 0, 16'h0);
        kick(16'h9999, 1'b0); await_done(34, 0, 16'h0);
        kick(16'h0100, 1'b0); await_done(34, 0, 16'h0);
        kick(16'h1234, 1'b0); await_done(34, 0, 16'h0);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) b[4*j +: 4] = 4'($urandom_range(0, 9));
            kick(b, 1'b0); await_done(34, 0, 16'h0);
        end
    endtask

    task automatic test_error();
        kick(16'h1234, 1'b0); await_done(34, 0, 16'h0);
        kick(16'h12A4, 1'b0); await_done(2, 0, 16'h0);
        kick(16'hF000, 1'b0); await_done(2, 0, 16'h0);
        kick(16'h000A, 1'b0); await_done(2, 0, 16'h0);
    endtask

    task automatic test_restart_ignored();
        kick(16'h1234, 1'b0);
        await_done(34, 10, 16'h9999);
        no_done(40, "restart_extra_done");
    endtask

    task automatic test_reset_abort();
        kick(16'h1234, 1'b0);
        repeat (14) begin @(posedge CLK); #1; end
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        exp_q.delete();
        last_bin = 16'h0000;
        n_checks++;
        if (BINOUT !== 16'h0000 || BUSY !== 1'b0 || DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL abort: BINOUT=%h BUSY=%b DONE=%b, required 0000 0 0", BINOUT, BUSY, DONE);
        end
        no_done(40, "abort_done");
        kick(16'h0042, 1'b0); await_done(34, 0, 16'h0);
    endtask

    task automatic test_back_to_back();
        logic [16:0] e;
        kick(16'h0100, 1'b0);
        repeat (33) begin @(posedge CLK); #1; end
        // START held through the DONE-state edge must only be taken in the next IDLE cycle
        BCD   = 16'h9999;
        START = 1'b1;
        push_exp(16'h9999, 1'b0);
        @(posedge CLK); #1;
        e = exp_q.pop_front();
        n_checks++;
        if (DONE !== 1'b1 || {ERR, BINOUT} !== e) begin
            n_fail++;
            $display("FAIL b2b_first: DONE=%b ERR=%b BINOUT=%h, required 1 %b %h", DONE, ERR, BINOUT, e[16], e[15:0]);
        end
        @(posedge CLK); #1;
        START = 1'b0;
        n_checks++;
        if (DONE !== 1'b0 || BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_start: DONE=%b BUSY=%b, required 0 1", DONE, BUSY);
        end
        await_done(34, 0, 16'h0);
    endtask

`ifdef BCD2BIN_SIGNED_EN
    task automatic test_signed();
        kick(16'h0042, 1'b1); await_done(34, 0, 16'h0);
        kick(16'h0000, 1'b1); await_done(34, 0, 16'h0);
        kick(16'h9999, 1'b1); await_done(34, 0, 16'h0);
        kick(16'h9A99, 1'b1); await_done(2, 0, 16'h0);
        SIGN = 1'b0;
    endtask
`endif

    initial begin
        RST   = 1'b1;
        START = 1'b0;
        BCD   = 16'h0000;
`ifdef BCD2BIN_SIGNED_EN
        SIGN  = 1'b0;
`endif
        last_bin = 16'h0000;
        test_reset();
        test_convert();
        test_error();
        test_restart_ignored();
        test_reset_abort();
        test_back_to_back();
`ifdef BCD2BIN_SIGNED_EN
        test_signed();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_to_binary.md
Name: bcd_to_binary

Overview:
- Sequential 4-digit packed-BCD to 16-bit unsigned binary converter. Uses the reverse double-dabble method: shift right, then subtract 3 from any digit that is 8 or more.
- Sits beside the display-path binary-to-BCD converter in the GYRO/ACC subsystem.
- Converts operator-entered decimal thresholds and scale values (switch or keypad digits) into binary for the sensor datapath.
- Uses a START/DONE handshake. Each conversion takes a fixed 34 clocks.

Parameters:
- NDIG, 4, number of BCD digits. Fixed at 4; any other value is unsupported.
- BW, 16, width of the binary result and the shift-register half-width.

Ports:
- CLK  in  1  system clock (100 MHz).
- RST  in  1  reset, synchronous, active-high; clock CLK.
- START  in  1  request a conversion. Sampled only in IDLE; ignored while BUSY.
- BCD  in  16  packed BCD, digit 3 (thousands) in [15:12] down to digit 0 (ones) in [3:0].
- BINOUT  out  16  registered binary result. Holds its value between conversions.
- DONE  out  1  one-cycle pulse when a conversion completes, valid or not.
- ERR  out  1  high for the DONE cycle if any input nibble was greater than 9.
- BUSY  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset values: BINOUT=0, DONE=0, ERR=0, BUSY=0, state=IDLE, shift register=0, shift count=0.
- RST asserted mid-conversion aborts immediately and returns everything to reset values. No DONE pulse is produced.
- Internal storage: 32-bit shift register tmp, where [31:16] is the BCD field and [15:0] is the binary field. Shift count is 5 bits.
- IDLE:
  - START=1 at edge k: tmp<={BCD,16'h0000}, count<=0, go to INIT. BCD is captured only at this edge.
  - Otherwise stay in IDLE.
- INIT: validate the four nibbles in tmp[31:16].
  - Any nibble greater than 9: set the internal error flag and go to DONE.
  - Otherwise clear the error flag and go to SHIFT.
- SHIFT: tmp<={1'b0,tmp[31:1]}, count<=count+1, go to CHECK.
- CHECK:
  - If count is not 16: for each nibble of tmp[31:16], if the nibble is 8 or more, nibble<=nibble-3. The four corrections are independent and happen in parallel in one cycle. Then go to SHIFT.
  - If count is 16: no correction; go to DONE.
- DONE: go to IDLE, clear tmp and count, assert DONE=1 for exactly this cycle.
  - Error flag clear: BINOUT<=tmp[15:0], ERR<=0.
  - Error flag set: BINOUT holds its prior value, ERR<=1.
- Latency: with START sampled at edge k, BINOUT, DONE and ERR are updated at edge k+34 (1 INIT + 16 SHIFT + 16 CHECK + 1 DONE). An error conversion completes at edge k+2.
- DONE and ERR return to 0 on the following edge. BUSY is high from edge k+1 up to the DONE-cycle edge, then low.
- START asserted during DONE is not seen; it is sampled on the next IDLE cycle. The minimum back-to-back period is 35 clocks.
- Arithmetic rules:
  - Corrections never underflow: the digit before the shift was at most 9, so a nibble that is 8 or more after the shift is at most 12.
  - After 16 shifts the upper field is all zero. The maximum result is 9999 (0x270F); BINOUT[15:14] is always 0.

Optional Feature:
- Macro BCD2BIN_SIGNED_EN.
- Defined:
  - Adds input port SIGN (1 bit), captured together with BCD at the START edge.
  - In a valid DONE cycle with SIGN=1: BINOUT<=~tmp[15:0]+1, the two's-complement negation.
  - -0 yields 0x0000. Range is -9999..+9999. An error conversion still leaves BINOUT unchanged.
- Undefined: no SIGN port; the output is always the unsigned magnitude.

Decomposition:
- Shared package bcd_pkg holds:
  - state encoding IDLE=3'b000, INIT=3'b001, SHIFT=3'b011, CHECK=3'b010, DONE=3'b110;
  - constants BCD_W=16, BIN_W=16, SHIFT_N=16;
  - the digit-valid limit value 9.
- One natural combinational sub-module: bcd_digit_adjust (4-bit in, 4-bit out; out = in>=8 ? in-3 : in). It is instantiated four times in CHECK.

Test Plan:
- BCD=16'h0000, START pulse -> DONE at k+34, BINOUT=16'h0000, ERR=0; BUSY high for cycles k+1..k+33.
- BCD=16'h9999 -> BINOUT=16'h270F. BCD=16'h1234 -> BINOUT=16'h04D2. BCD=16'h0100 -> BINOUT=16'h0064.
- BCD=16'h12A4 -> DONE and ERR both high at edge k+2; BINOUT keeps the previous 16'h04D2.
- START re-pulsed at k+10 during 16'h1234 conversion -> ignored; a single DONE at k+34 with 16'h04D2.
- RST at k+15 during conversion -> next cycle BINOUT=0, BUSY=0, no DONE; a following 16'h0042 conversion gives 16'h002A.
- With BCD2BIN_SIGNED_EN: SIGN=1, BCD=16'h0042 -> BINOUT=16'hFFD6; SIGN=1, BCD=16'h0000 -> BINOUT=16'h0000.
